// File: rtl/npu_stream_loader_if.sv
// Bus bundle between the stream loader and its neighbours: source memory
// read port, shared NPU data bus and the valid/ready result stream.
interface npu_stream_loader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              npu_we;
    logic [DATA_W-1:0] npu_wdata;
    logic              npu_oe;
    logic [DATA_W-1:0] npu_rdata;
    logic              npu_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output npu_we, npu_wdata, npu_oe,
        input  npu_rdata, npu_ready,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  npu_we, npu_wdata, npu_oe,
        output npu_rdata, npu_ready,
        input  out_valid, out_data,
        output out_ready
    );
endinterface

// File: rtl/npu_stream_loader.sv
// Host-side sequencer: streams header, weights and per-batch inputs from
// source memory onto the NPU bus, then drains results into a valid/ready stream.
module npu_stream_loader #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 12,
    parameter int CNT_W   = 12,
    parameter int OUT_W   = 5,
    parameter int BATCH_W = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   cfg_num_w,
    input  logic [CNT_W-1:0]   cfg_num_in,
    input  logic [OUT_W-1:0]   cfg_num_out,
    input  logic [BATCH_W-1:0] cfg_batches,
    input  logic [TMO_W-1:0]   cfg_timeout,
    npu_stream_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WGT, S_IN, S_DRAIN, S_WAIT, S_RD, S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(5);

    state_t             state_q, state_d, after_load;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   num_w_q, num_w_d, num_in_q, num_in_d;
    logic [OUT_W-1:0]   num_out_q, num_out_d, out_cnt_q, out_cnt_d;
    logic [BATCH_W-1:0] batch_q, batch_d;
    logic [TMO_W-1:0]   tmo_lim_q, tmo_lim_d, tmo_q, tmo_d, tmo_inc;
    logic               err_q, err_d, we_q, we_d, out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               rd, oe;

    assign tmo_inc = tmo_q + 1'b1;

    // Destination once header and weights have been issued.
    always_comb begin
        after_load = S_IN;
        if (batch_q == '0)
            after_load = S_DRAIN;
        else if (num_in_q == '0)
            after_load = S_WAIT;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        num_w_d     = num_w_q;
        num_in_d    = num_in_q;
        num_out_d   = num_out_q;
        batch_d     = batch_q;
        tmo_lim_d   = tmo_lim_q;
        tmo_d       = '0;
        out_cnt_d   = '0;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rd          = 1'b0;
        oe          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_w_d   = cfg_num_w;
                    num_in_d  = cfg_num_in;
                    num_out_d = cfg_num_out;
                    batch_d   = cfg_batches;
                    tmo_lim_d = cfg_timeout;
                    err_d     = 1'b0;
                    rd        = 1'b1;
                    addr_d    = base_addr + 1'b1;
                    cnt_d     = CNT_W'(1);
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                rd     = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == HDR_LAST) begin
                    cnt_d   = '0;
                    state_d = (num_w_q != '0) ? S_WGT : after_load;
                end
            end
            S_WGT: begin
                rd     = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == num_w_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = after_load;
                end
            end
            S_IN: begin
                rd     = 1'b1;
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == num_in_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = (batch_q == '0) ? S_FIN : S_WAIT;
            end
            S_WAIT: begin
                // A ready seen in the same cycle as the limit still wins.
                if (bus.npu_ready) begin
                    state_d = S_RD;
                end else if (tmo_lim_q != '0 && tmo_inc == tmo_lim_q) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_RD: begin
                out_cnt_d = out_cnt_q;
                oe = (out_cnt_q < num_out_q) && (!out_valid_q || bus.out_ready);
                if (oe) begin
                    out_data_d  = bus.npu_rdata;
                    out_valid_d = 1'b1;
                    out_cnt_d   = out_cnt_q + 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (out_cnt_q == num_out_q && !out_valid_q) begin
                    batch_d = batch_q - 1'b1;
                    if (batch_q > BATCH_W'(1))
                        state_d = (num_in_q == '0) ? S_WAIT : S_IN;
                    else
                        state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        we_d = rd;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            num_w_q     <= '0;
            num_in_q    <= '0;
            num_out_q   <= '0;
            batch_q     <= '0;
            tmo_lim_q   <= '0;
            tmo_q       <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            num_w_q     <= num_w_d;
            num_in_q    <= num_in_d;
            num_out_q   <= num_out_d;
            batch_q     <= batch_d;
            tmo_lim_q   <= tmo_lim_d;
            tmo_q       <= tmo_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            we_q        <= we_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // The first header read is issued from IDLE, before the pointer is loaded.
    assign bus.mem_rd    = rd;
    assign bus.mem_addr  = !rd ? '0 : (state_q == S_IDLE) ? base_addr : addr_q;
    assign bus.npu_we    = we_q;
    assign bus.npu_wdata = we_q ? bus.mem_rdata : '0;
    assign bus.npu_oe    = oe;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign err           = err_q;
endmodule

// File: tb/tb_npu_stream_loader.sv
// Directed bench for npu_stream_loader: a job-level model predicts read
// addresses, write words and result order; a per-cycle process compares.
module tb_npu_stream_loader;
    localparam int DATA_W = 32, ADDR_W = 12, CNT_W = 12, OUT_W = 5, BATCH_W = 8, TMO_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [ADDR_W-1:0]  base_addr = '0;
    logic [CNT_W-1:0]   cfg_num_w = '0;
    logic [CNT_W-1:0]   cfg_num_in = '0;
    logic [OUT_W-1:0]   cfg_num_out = '0;
    logic [BATCH_W-1:0] cfg_batches = '0;
    logic [TMO_W-1:0]   cfg_timeout = '0;
    logic               busy, done, err;

    int ready_delay  = 0;   // 0 = the NPU never raises npu_ready
    bit toggle_ready = 1'b0;
    int n_checks = 0, n_fail = 0;

    logic [DATA_W-1:0] mem [0:4095];

    // Model state and logs, owned by the compare process.
    logic [ADDR_W-1:0] exp_addr[$];
    logic [ADDR_W-1:0] exp_wr[$];
    logic [DATA_W-1:0] exp_out[$];
    logic [ADDR_W-1:0] rd_log[$];
    logic [DATA_W-1:0] out_log[$];
    bit model_busy = 1'b0, exp_err = 1'b0, we_prev = 1'b0;
    int out_idx = 0, cyc = 0;
    int rd_cnt = 0, we_cnt = 0, we_rises = 0, oe_cnt = 0, done_cnt = 0;
    int last_we_cyc = 0, done_cyc = 0;

    npu_stream_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    npu_stream_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
        .OUT_W(OUT_W), .BATCH_W(BATCH_W), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .cfg_num_w(cfg_num_w), .cfg_num_in(cfg_num_in), .cfg_num_out(cfg_num_out),
        .cfg_batches(cfg_batches), .cfg_timeout(cfg_timeout),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source memory (1-cycle read latency) and NPU: results numbered in oe order.
    initial begin
        logic rd_s, oe_s, we_s, armed;
        logic [ADDR_W-1:0] a_s;
        int npu_idx, wcnt;
        npu_idx = 0; wcnt = 0; armed = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        bus.npu_ready = 1'b0;
        bus.npu_rdata = 32'hC0DE_0000;
        forever begin
            @(negedge clk);
            rd_s = bus.mem_rd; a_s = bus.mem_addr; oe_s = bus.npu_oe; we_s = bus.npu_we;
            @(posedge clk); #1;
            if (!rst) begin
                bus.mem_rdata = 32'hDEAD_BEEF;
                npu_idx = 0; wcnt = 0; armed = 1'b0;
                bus.npu_ready = 1'b0;
            end else begin
                bus.mem_rdata = rd_s ? mem[a_s] : 32'hDEAD_BEEF;
                if (oe_s) npu_idx++;
                if (we_s) begin
                    armed = 1'b1; wcnt = 0; bus.npu_ready = 1'b0;
                end else if (armed && ready_delay != 0) begin
                    wcnt++;
                    if (wcnt >= ready_delay) bus.npu_ready = 1'b1;
                end
            end
            bus.npu_rdata = 32'hC0DE_0000 + 32'(npu_idx);
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = toggle_ready ? ~bus.out_ready : 1'b1;
        end
    end

    // Model + compare: an accepted job expands into the full address list,
    // write list and ordered result list; each cycle consumes from them.
    initial begin
        int nb, nreads, nouts;
        bit will_tmo;
        logic [ADDR_W-1:0] a;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                exp_addr.delete(); exp_wr.delete(); exp_out.delete();
                model_busy = 1'b0; out_idx = 0; we_prev = 1'b0;
            end else begin
                if (start && !model_busy) begin
                    model_busy = 1'b1;
                    nb = int'(cfg_batches);
                    will_tmo = (ready_delay == 0) && (cfg_timeout != '0) && (nb != 0);
                    nreads = 6 + int'(cfg_num_w) +
                             ((nb == 0) ? 0 : (will_tmo ? int'(cfg_num_in) : nb * int'(cfg_num_in)));
                    for (int i = 0; i < nreads; i++) begin
                        a = base_addr + ADDR_W'(i);
                        exp_addr.push_back(a);
                        exp_wr.push_back(a);
                    end
                    nouts = will_tmo ? 0 : nb * int'(cfg_num_out);
                    for (int k = 0; k < nouts; k++) begin
                        exp_out.push_back(32'hC0DE_0000 + 32'(out_idx));
                        out_idx++;
                    end
                    exp_err = will_tmo;
                end
                if (bus.mem_rd) begin
                    rd_cnt++;
                    rd_log.push_back(bus.mem_addr);
                    chk("read_expected", exp_addr.size() != 0, 1);
                    if (exp_addr.size() != 0) chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
                end
                if (bus.npu_we) begin
                    we_cnt++;
                    if (!we_prev) we_rises++;
                    last_we_cyc = cyc;
                    chk("write_expected", exp_wr.size() != 0, 1);
                    if (exp_wr.size() != 0) chk("npu_wdata", bus.npu_wdata, mem[exp_wr.pop_front()]);
                end else begin
                    chk("npu_wdata_idle", bus.npu_wdata, 0);
                end
                we_prev = bus.npu_we;
                chk("we_oe_exclusive", bus.npu_we & bus.npu_oe, 0);
                if (bus.npu_oe) begin
                    oe_cnt++;
                    chk("oe_while_stalled", bus.out_valid & ~bus.out_ready, 0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    out_log.push_back(bus.out_data);
                    chk("out_expected", exp_out.size() != 0, 1);
                    if (exp_out.size() != 0) chk("out_data", bus.out_data, exp_out.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("err_at_done", err, exp_err);
                    model_busy = 1'b0;
                end
            end
        end
    end

    task automatic kick(input logic [ADDR_W-1:0] b, input int nw, input int nin,
                        input int nout, input int nb, input int tmo);
        @(posedge clk); #1;
        base_addr = b; cfg_num_w = CNT_W'(nw); cfg_num_in = CNT_W'(nin);
        cfg_num_out = OUT_W'(nout); cfg_batches = BATCH_W'(nb); cfg_timeout = TMO_W'(tmo);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 12'h555; cfg_num_w = 12'd7; cfg_num_in = 12'd9;
        cfg_num_out = 5'd3; cfg_batches = 8'd5; cfg_timeout = 16'd3;
    endtask

    task automatic wait_done(input int d0, input int bound);
        int n = 0;
        while (done_cnt == d0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_bound", done_cnt != d0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic job_end(input string tag);
        chk({tag, "_reads_left"}, exp_addr.size(), 0);
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        chk({tag, "_outs_left"}, exp_out.size(), 0);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mem_rd"}, bus.mem_rd, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_npu_we"}, bus.npu_we, 0);
        chk({tag, "_npu_wdata"}, bus.npu_wdata, 0);
        chk({tag, "_npu_oe"}, bus.npu_oe, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, we0, wr0, oe0, ol0, d0, rda;
        logic [ADDR_W-1:0] wrap_exp [6];
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);

        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        rst = 1'b1;

        // Job 1: single batch, ready 20 cycles after last write.
        ready_delay = 20;
        rd0 = rd_cnt; we0 = we_cnt; wr0 = we_rises; oe0 = oe_cnt; ol0 = out_log.size(); d0 = done_cnt;
        kick(12'h000, 11, 10, 1, 1, 0);
        wait_done(d0, 500);
        job_end("job1");
        chk("job1_reads", rd_cnt - rd0, 27);
        chk("job1_last_addr", rd_log[rd0 + 26], 26);
        chk("job1_writes", we_cnt - we0, 27);
        chk("job1_we_bursts", we_rises - wr0, 1);
        chk("job1_oe", oe_cnt - oe0, 1);
        chk("job1_outs", out_log.size() - ol0, 1);
        if (out_log.size() > ol0) chk("job1_out_word", out_log[ol0], 32'hC0DE_0000);
        chk("job1_done", done_cnt - d0, 1);
        chk("job1_err", err, 0);

        // Job 2: three batches, weights once; a stray start mid-job is ignored.
        ready_delay = 5;
        rd0 = rd_cnt; we0 = we_cnt; wr0 = we_rises; oe0 = oe_cnt; ol0 = out_log.size(); d0 = done_cnt;
        kick(12'h100, 5, 4, 2, 3, 0);
        repeat (8) @(posedge clk);
        kick(12'h800, 1, 1, 1, 1, 0);
        wait_done(d0, 800);
        job_end("job2");
        chk("job2_reads", rd_cnt - rd0, 23);
        chk("job2_batch1_first_in", rd_log[rd0 + 11], 12'h10B);
        chk("job2_last_addr", rd_log[rd0 + 22], 12'h116);
        chk("job2_writes", we_cnt - we0, 23);
        chk("job2_we_bursts", we_rises - wr0, 3);
        chk("job2_oe", oe_cnt - oe0, 6);
        chk("job2_outs", out_log.size() - ol0, 6);
        if (out_log.size() >= ol0 + 6) chk("job2_last_out", out_log[ol0 + 5], 32'hC0DE_0006);
        chk("job2_done", done_cnt - d0, 1);

        // Job 3: downstream ready toggling.
        ready_delay = 4;
        toggle_ready = 1'b1;
        rd0 = rd_cnt; oe0 = oe_cnt; ol0 = out_log.size(); d0 = done_cnt;
        kick(12'h200, 2, 3, 4, 1, 0);
        wait_done(d0, 500);
        toggle_ready = 1'b0;
        job_end("job3");
        chk("job3_reads", rd_cnt - rd0, 11);
        chk("job3_oe", oe_cnt - oe0, 4);
        chk("job3_outs", out_log.size() - ol0, 4);
        if (out_log.size() >= ol0 + 4) begin
            chk("job3_first_out", out_log[ol0], 32'hC0DE_0007);
            chk("job3_last_out", out_log[ol0 + 3], 32'hC0DE_000A);
        end
        chk("job3_done", done_cnt - d0, 1);

        // Job 4: NPU never ready, timeout of 100 wait cycles.
        ready_delay = 0;
        rd0 = rd_cnt; oe0 = oe_cnt; ol0 = out_log.size(); d0 = done_cnt;
        kick(12'h300, 1, 2, 2, 1, 100);
        wait_done(d0, 1000);
        job_end("job4");
        chk("job4_err_sticky", err, 1);
        chk("job4_reads", rd_cnt - rd0, 9);
        chk("job4_oe", oe_cnt - oe0, 0);
        chk("job4_outs", out_log.size() - ol0, 0);
        chk("job4_wait_span", done_cyc - last_we_cyc, 101);

        // Job 5: address wrap, no weights, no batches.
        ready_delay = 5;
        wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000;
        wrap_exp[3] = 12'h001; wrap_exp[4] = 12'h002; wrap_exp[5] = 12'h003;
        rd0 = rd_cnt; we0 = we_cnt; oe0 = oe_cnt; d0 = done_cnt;
        kick(12'hFFE, 0, 0, 3, 0, 0);
        chk("job5_err_cleared", err, 0);
        wait_done(d0, 200);
        job_end("job5");
        chk("job5_reads", rd_cnt - rd0, 6);
        for (int i = 0; i < 6; i++)
            if (rd_cnt - rd0 > i) chk($sformatf("job5_addr%0d", i), rd_log[rd0 + i], wrap_exp[i]);
        chk("job5_writes", we_cnt - we0, 6);
        chk("job5_oe", oe_cnt - oe0, 0);
        chk("job5_done", done_cnt - d0, 1);

        // Job 6: asynchronous reset in the middle of the weight phase.
        d0 = done_cnt;
        kick(12'h400, 40, 4, 1, 1, 0);
        repeat (10) @(posedge clk);
        chk("job6_busy_before_reset", busy, 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        rda = rd_cnt;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("postreset_no_reads", rd_cnt - rda, 0);
        chk("postreset_busy", busy, 0);
        chk("postreset_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
